// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU I/O bridge: I/O window register offsets and STATUS bit layout.
package cpu_io_pkg;

    localparam logic [3:0] IO_TXDATA  = 4'd0;
    localparam logic [3:0] IO_STATUS  = 4'd1;
    localparam logic [3:0] IO_CYCLO   = 4'd2;
    localparam logic [3:0] IO_CYCHI   = 4'd3;
    localparam logic [3:0] IO_SCRATCH = 4'd4;

    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_CNT_LSB   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam int unsigned Depth    = 1 << AW;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

    logic [WIDTH-1:0] mem_q [Depth];
    logic [WIDTH-1:0] mem_d [Depth];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_fire, pop_fire;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign pop_fire  = pop_i & ~empty_o;
    assign push_fire = push_i & (~full_o | pop_fire);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_fire) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop_fire) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: entries are only observable once pushed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// CPU memory-port bridge: 16-word I/O window (TX FIFO, status, scratch, cycle counter), rest to RAM.
// Define CPU_IO_CYCLE_COUNTER_EN to build the 32-bit cycle counter and its high-half latch.
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int unsigned       AWIDTH  = 16,
    parameter int unsigned       DWIDTH  = 16,
    parameter logic [AWIDTH-1:0] IO_BASE = 16'hFFF0,
    parameter int unsigned       FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] cpu_raddr_i,
    input  logic              cpu_rd_i,
    output logic [DWIDTH-1:0] cpu_rdata_o,
    input  logic [AWIDTH-1:0] cpu_waddr_i,
    input  logic [DWIDTH-1:0] cpu_wdata_i,
    input  logic              cpu_wr_i,
    output logic [AWIDTH-1:0] ram_raddr_o,
    input  logic [DWIDTH-1:0] ram_rdata_i,
    output logic [AWIDTH-1:0] ram_waddr_o,
    output logic [DWIDTH-1:0] ram_wdata_o,
    output logic              ram_wr_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    logic              rd_in_win, wr_in_win;
    logic [3:0]        rd_off, wr_off;
    logic              tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic [FIFO_AW:0]  tx_count;
    logic              status_rd;
    logic [DWIDTH-1:0] status_word, io_mux;

    logic              rd_is_io_q, rd_is_io_d;
    logic [DWIDTH-1:0] io_rdata_q, io_rdata_d;
    logic [DWIDTH-1:0] scratch_q, scratch_d;
    logic              ovf_q, ovf_d;
`ifdef CPU_IO_CYCLE_COUNTER_EN
    logic [31:0]       cyc_q, cyc_d;
    logic [15:0]       hi_q, hi_d;
`endif

    assign rd_in_win = (cpu_raddr_i[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4]);
    assign wr_in_win = (cpu_waddr_i[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4]);
    assign rd_off    = cpu_raddr_i[3:0];
    assign wr_off    = cpu_waddr_i[3:0];

    assign ram_raddr_o = cpu_raddr_i;
    assign ram_waddr_o = cpu_waddr_i;
    assign ram_wdata_o = cpu_wdata_i;
    assign ram_wr_o    = cpu_wr_i & ~wr_in_win;

    assign tx_push   = cpu_wr_i & wr_in_win & (wr_off == IO_TXDATA);
    assign tx_pop    = tx_valid_o & tx_ready_i;
    assign tx_drop   = tx_push & tx_full & ~tx_pop;
    assign status_rd = cpu_rd_i & rd_in_win & (rd_off == IO_STATUS);

    assign tx_valid_o  = ~tx_empty;
    assign cpu_rdata_o = rd_is_io_q ? io_rdata_q : ram_rdata_i;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .wdata_i (cpu_wdata_i[7:0]),
        .pop_i   (tx_pop),
        .rdata_o (tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    always_comb begin
        status_word                                   = '0;
        status_word[STATUS_FULL_BIT]                  = tx_full;
        status_word[STATUS_EMPTY_BIT]                 = tx_empty;
        status_word[STATUS_OVF_BIT]                   = ovf_q;
        status_word[STATUS_CNT_LSB +: FIFO_AW + 1]    = tx_count;

        io_mux = '0;
        case (rd_off)
            IO_STATUS:  io_mux = status_word;
            IO_SCRATCH: io_mux = scratch_q;
`ifdef CPU_IO_CYCLE_COUNTER_EN
            IO_CYCLO:   io_mux[15:0] = cyc_q[15:0];
            IO_CYCHI:   io_mux[15:0] = hi_q;
`endif
            default:    io_mux = '0;
        endcase
    end

    always_comb begin
        rd_is_io_d = rd_in_win & cpu_rd_i;
        io_rdata_d = io_mux;
        scratch_d  = (cpu_wr_i & wr_in_win & (wr_off == IO_SCRATCH)) ? cpu_wdata_i : scratch_q;
        // A drop in the same cycle as a STATUS read must stay visible on the next read.
        ovf_d      = (ovf_q & ~status_rd) | tx_drop;
`ifdef CPU_IO_CYCLE_COUNTER_EN
        cyc_d      = cyc_q + 32'd1;
        hi_d       = (cpu_rd_i & rd_in_win & (rd_off == IO_CYCLO)) ? cyc_q[31:16] : hi_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_is_io_q <= 1'b0;
            io_rdata_q <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
`ifdef CPU_IO_CYCLE_COUNTER_EN
            cyc_q      <= '0;
            hi_q       <= '0;
`endif
        end else begin
            rd_is_io_q <= rd_is_io_d;
            io_rdata_q <= io_rdata_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
`ifdef CPU_IO_CYCLE_COUNTER_EN
            cyc_q      <= cyc_d;
            hi_q       <= hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed self-checking bench for cpu_io_bridge with a behavioural 1-cycle synchronous RAM.
module tb_cpu_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_raddr, cpu_waddr, cpu_wdata, cpu_rdata;
    logic        cpu_rd, cpu_wr;
    logic [15:0] ram_raddr, ram_waddr, ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic        ram_wr;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    logic [15:0] ram_mem [256];
    logic [31:0] model_cyc = '0;
    int unsigned io_ram_wr_seen = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    cpu_io_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_raddr_i (cpu_raddr),
        .cpu_rd_i    (cpu_rd),
        .cpu_rdata_o (cpu_rdata),
        .cpu_waddr_i (cpu_waddr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_wr_i    (cpu_wr),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_wr_o    (ram_wr),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready)
    );

    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_waddr[7:0]] <= ram_wdata;
        ram_rdata <= ram_mem[ram_raddr[7:0]];
        if (ram_wr && ram_waddr[15:4] == 12'hFFF) io_ram_wr_seen <= io_ram_wr_seen + 1;
        model_cyc <= rst ? 32'd0 : model_cyc + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Both tasks start and end on a falling edge, spanning exactly one rising edge.
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        cpu_waddr = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        @(negedge clk);
        cpu_wr    = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        cpu_raddr = a;
        cpu_rd    = 1'b1;
        @(negedge clk);
        cpu_rd    = 1'b0;
        d         = cpu_rdata;
    endtask

    initial begin
        logic [15:0] rd;
        logic [31:0] exp_cyc;

        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        rst = 1'b1; cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("reset_rdata_ram", {16'd0, cpu_rdata}, 32'd0);
        rst = 1'b0;

`ifdef CPU_IO_CYCLE_COUNTER_EN
        repeat (100) @(negedge clk);
        exp_cyc = model_cyc;
        cpu_read(16'hFFF2, rd);
        check_eq("cyc_lo_100", {16'd0, rd}, {16'd0, exp_cyc[15:0]});
        cpu_read(16'hFFF3, rd);
        check_eq("cyc_hi_100", {16'd0, rd}, 32'd0);
        force dut.cyc_q = 32'h0000FFFF;
        cpu_read(16'hFFF2, rd);
        release dut.cyc_q;
        check_eq("cyc_lo_ffff", {16'd0, rd}, 32'h0000FFFF);
        cpu_read(16'hFFF3, rd);
        check_eq("cyc_hi_latched", {16'd0, rd}, 32'd0);
`else
        exp_cyc = 32'd0;
        repeat (100) @(negedge clk);
        cpu_read(16'hFFF2, rd);
        check_eq("cyc_lo_absent", {16'd0, rd}, exp_cyc);
        cpu_read(16'hFFF3, rd);
        check_eq("cyc_hi_absent", {16'd0, rd}, exp_cyc);
`endif

        cpu_read(16'hFFF1, rd);
        check_eq("status_reset", {16'd0, rd}, 32'h0002);

        cpu_write(16'h0010, 16'h1234);
        cpu_write(16'h0020, 16'hA5A5);
        cpu_read(16'h0010, rd);
        check_eq("ram_rd_0010", {16'd0, rd}, 32'h1234);
        cpu_read(16'h0020, rd);
        check_eq("ram_rd_0020", {16'd0, rd}, 32'hA5A5);

        for (int i = 0; i < 5; i++) cpu_write(16'hFFF0, 16'h0041 + 16'(i));
        cpu_read(16'hFFF1, rd);
        check_eq("status_ovf", {16'd0, rd}, 32'h0405);
        cpu_read(16'hFFF1, rd);
        check_eq("status_ovf_clr", {16'd0, rd}, 32'h0401);
        cpu_read(16'hFFF0, rd);
        check_eq("txdata_rd_zero", {16'd0, rd}, 32'd0);
        check_eq("tx_hold_data", {24'd0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", {31'd0, tx_valid}, 32'd1);
            check_eq("drain_data", {24'd0, tx_data}, 32'h41 + i);
            @(negedge clk);
        end
        check_eq("drain_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        cpu_read(16'hFFF1, rd);
        check_eq("status_empty", {16'd0, rd}, 32'h0002);

        for (int i = 0; i < 4; i++) cpu_write(16'hFFF0, 16'h0061 + 16'(i));
        tx_ready = 1'b1;
        cpu_write(16'hFFF0, 16'h0055);
        tx_ready = 1'b0;
        cpu_read(16'hFFF1, rd);
        check_eq("status_push_pop_full", {16'd0, rd}, 32'h0401);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("pp_data", {24'd0, tx_data}, (i == 3) ? 32'h55 : 32'h62 + i);
            @(negedge clk);
        end
        check_eq("pp_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        cpu_waddr = 16'hFFF4; cpu_wdata = 16'hBEEF; cpu_wr = 1'b1;
        cpu_read(16'hFFF4, rd);
        cpu_wr = 1'b0;
        check_eq("scratch_same_cycle", {16'd0, rd}, 32'd0);
        cpu_read(16'hFFF4, rd);
        check_eq("scratch_readback", {16'd0, rd}, 32'hBEEF);
        cpu_write(16'hFFF9, 16'h7777);
        cpu_read(16'hFFF9, rd);
        check_eq("offset9_zero", {16'd0, rd}, 32'd0);

        for (int i = 0; i < 3; i++) cpu_write(16'hFFF0, 16'h0070 + 16'(i));
        check_eq("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midreset_valid", {31'd0, tx_valid}, 32'd0);
        rst = 1'b0;
        cpu_read(16'hFFF1, rd);
        check_eq("midreset_status", {16'd0, rd}, 32'h0002);
        cpu_read(16'hFFF4, rd);
        check_eq("midreset_scratch", {16'd0, rd}, 32'd0);

        check_eq("no_io_ram_wr", io_ram_wr_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
